// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the load/store unit: decoder mem_op/mem_sel fields and LSU FSM states.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package mem_access_unit_pkg;

    // Decoder mem_op field
    localparam logic [1:0] MEM_OP_NOP   = 2'd0;
    localparam logic [1:0] MEM_OP_LOAD  = 2'd1;
    localparam logic [1:0] MEM_OP_STORE = 2'd2;

    // Decoder mem_sel field (access width / signedness)
    localparam logic [2:0] MEM_SEL_NOP = 3'd0;
    localparam logic [2:0] MEM_SEL_B   = 3'd1;
    localparam logic [2:0] MEM_SEL_H   = 3'd2;
    localparam logic [2:0] MEM_SEL_W   = 3'd3;
    localparam logic [2:0] MEM_SEL_BU  = 3'd4;
    localparam logic [2:0] MEM_SEL_HU  = 3'd5;

    // LSU FSM states, exported so benches can name them
    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_RESP   = 2'd2
    } lsu_state_e;

    // Only the five real widths start a bus access; anything else behaves as NOP.
    function automatic logic sel_is_access(input logic [2:0] sel);
        case (sel)
            MEM_SEL_B, MEM_SEL_H, MEM_SEL_W, MEM_SEL_BU, MEM_SEL_HU: sel_is_access = 1'b1;
            default:                                                 sel_is_access = 1'b0;
        endcase
    endfunction

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic is_misaligned(input logic [2:0] sel, input logic [1:0] off);
        case (sel)
            MEM_SEL_H, MEM_SEL_HU: is_misaligned = off[0];
            MEM_SEL_W:             is_misaligned = (off != 2'b00);
            default:               is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Byte-lane steering: store byte enables / lane replication and load extraction with extension.
// Latency: purely combinational, 0 cycles.
// Backpressure: none (no handshake).
// Ports: i_sel access width, i_off byte offset, i_wdata store data, i_rdata bus read word,
//        o_be byte enables, o_wdata lane-replicated store data, o_rdata_ext extended load data.
module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [2:0]  i_sel,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_rdata_ext
);

    logic [31:0] w_shifted;

    // Move the addressed byte/halfword down to bit 0 before extending.
    assign w_shifted = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_be        = 4'b0000;
        o_wdata     = i_wdata;
        o_rdata_ext = 32'h0;
        case (i_sel)
            MEM_SEL_B: begin
                o_be        = 4'b0001 << i_off;
                o_wdata     = {4{i_wdata[7:0]}};
                o_rdata_ext = {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            MEM_SEL_BU: begin
                o_be        = 4'b0001 << i_off;
                o_wdata     = {4{i_wdata[7:0]}};
                o_rdata_ext = {24'h0, w_shifted[7:0]};
            end
            MEM_SEL_H: begin
                o_be        = 4'b0011 << i_off;
                o_wdata     = {2{i_wdata[15:0]}};
                o_rdata_ext = {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            MEM_SEL_HU: begin
                o_be        = 4'b0011 << i_off;
                o_wdata     = {2{i_wdata[15:0]}};
                o_rdata_ext = {16'h0, w_shifted[15:0]};
            end
            MEM_SEL_W: begin
                o_be        = 4'b1111;
                o_wdata     = i_wdata;
                o_rdata_ext = w_shifted;
            end
            default: begin
                o_be        = 4'b0000;
                o_wdata     = i_wdata;
                o_rdata_ext = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: runs one req/ack data-memory transaction per request and returns extended load data.
// Latency: NOP/misaligned 1 cycle start->done; bus access 2 cycles plus bus wait cycles.
// Backpressure: busy stalls the core from the cycle after start until the cycle after done.
// Ports: core side start/mem_op/mem_sel/addr/wdata in, busy/done/rdata/misalign_err/bus_err out;
//        memory side bus_req/bus_we/bus_addr/bus_be/bus_wdata out, bus_ack/bus_rdata in.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        mem_op,
    input  logic [2:0]        mem_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              misalign_err,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_ack,
    input  logic [31:0]       bus_rdata
);

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic            TO_EN    = (TIMEOUT_CYCLES != 0);

    lsu_state_e        r_state;
    lsu_state_e        w_next_state;

    logic              r_busy;
    logic              r_done;
    logic [31:0]       r_rdata;
    logic              r_misalign_err;
    logic              r_bus_err;
    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [3:0]        r_bus_be;
    logic [31:0]       r_bus_wdata;
    logic              r_is_load;
    logic [2:0]        r_sel;
    logic [1:0]        r_off;
    logic [CNT_W-1:0]  r_cnt;

    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_req_nop;
    logic              w_req_mis;
    logic              w_launch;
    logic              w_set_mis;
    logic              w_complete;
    logic              w_abort;
    logic [2:0]        w_al_sel;
    logic [1:0]        w_al_off;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata_rep;
    logic [31:0]       w_rdata_ext;

    assign w_req_nop = !((mem_op == MEM_OP_LOAD) || (mem_op == MEM_OP_STORE)) || !sel_is_access(mem_sel);
    assign w_req_mis = is_misaligned(mem_sel, addr[1:0]);
    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // In IDLE the aligner builds enables/store lanes from the live request;
    // afterwards it extracts load data using the latched width and offset.
    assign w_al_sel = (r_state == LSU_IDLE) ? mem_sel   : r_sel;
    assign w_al_off = (r_state == LSU_IDLE) ? addr[1:0] : r_off;

    mem_lane_align u_lane_align (
        .i_sel       (w_al_sel),
        .i_off       (w_al_off),
        .i_wdata     (wdata),
        .i_rdata     (bus_rdata),
        .o_be        (w_be),
        .o_wdata     (w_wdata_rep),
        .o_rdata_ext (w_rdata_ext)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_launch     = 1'b0;
        w_set_mis    = 1'b0;
        w_complete   = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            LSU_IDLE: begin
                if (start) begin
                    if (w_req_nop) begin
                        w_next_state = LSU_RESP;
                    end else if (w_req_mis) begin
                        w_next_state = LSU_RESP;
                        w_set_mis    = 1'b1;
                    end else begin
                        w_next_state = LSU_ACCESS;
                        w_launch     = 1'b1;
                    end
                end
            end
            LSU_ACCESS: begin
                // An ack wins over a timeout expiring in the same cycle.
                if (bus_ack) begin
                    w_next_state = LSU_RESP;
                    w_complete   = 1'b1;
                end else if (TO_EN && (w_cnt_inc == TO_LIMIT)) begin
                    w_next_state = LSU_RESP;
                    w_abort      = 1'b1;
                end
            end
            LSU_RESP: begin
                w_next_state = LSU_IDLE;
            end
            default: begin
                w_next_state = LSU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_rdata        <= 32'h0;
            r_misalign_err <= 1'b0;
            r_bus_err      <= 1'b0;
            r_bus_req      <= 1'b0;
            r_bus_we       <= 1'b0;
            r_bus_addr     <= '0;
            r_bus_be       <= 4'b0000;
            r_bus_wdata    <= 32'h0;
            r_is_load      <= 1'b0;
            r_sel          <= MEM_SEL_NOP;
            r_off          <= 2'b00;
            r_cnt          <= '0;
        end else begin
            r_busy <= (w_next_state != LSU_IDLE);
            r_done <= (w_next_state == LSU_RESP);

            if (w_launch) begin
                r_is_load   <= (mem_op == MEM_OP_LOAD);
                r_sel       <= mem_sel;
                r_off       <= addr[1:0];
                r_bus_req   <= 1'b1;
                r_bus_we    <= (mem_op == MEM_OP_STORE);
                r_bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                r_bus_be    <= w_be;
                r_bus_wdata <= w_wdata_rep;
                r_cnt       <= '0;
            end else if ((r_state == LSU_ACCESS) && !bus_ack) begin
                r_cnt <= w_cnt_inc;
            end

            if (w_complete || w_abort) begin
                r_bus_req <= 1'b0;
            end

            if (w_complete && r_is_load) begin
                r_rdata <= w_rdata_ext;
            end

            // Error flags live exactly for the RESP cycle.
            if (r_state == LSU_RESP) begin
                r_misalign_err <= 1'b0;
                r_bus_err      <= 1'b0;
            end else begin
                if (w_set_mis) begin
                    r_misalign_err <= 1'b1;
                end
                if (w_abort) begin
                    r_bus_err <= 1'b1;
                end
            end
        end
    end

    assign busy         = r_busy;
    assign done         = r_done;
    assign rdata        = r_rdata;
    assign misalign_err = r_misalign_err;
    assign bus_err      = r_bus_err;
    assign bus_req      = r_bus_req;
    assign bus_we       = r_bus_we;
    assign bus_addr     = r_bus_addr;
    assign bus_be       = r_bus_be;
    assign bus_wdata    = r_bus_wdata;

endmodule
